// File: rtl/spm_pkg.sv
// Shared types and default sizing for the serial-parallel multiplier and its controller.
package spm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } spm_state_t;

    localparam int SPM_WIDTH = 32;
    localparam int SPM_PLAT  = 1;

endpackage

// File: rtl/spm_deser.sv
// Serial-in shift register (LSB arrives first, enters at the MSB end) with a
// separate hold register that captures the assembled word on load.
module spm_deser #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         shift_en,
    input  logic         din,
    input  logic         load,
    output logic [N-1:0] dout
);

    logic [N-1:0] pr_q, pr_d;
    logic [N-1:0] dout_q, dout_d;

    // load sees the post-shift word so the bit arriving on the load cycle is kept
    always_comb begin
        pr_d   = pr_q;
        dout_d = dout_q;
        if (shift_en) begin
            pr_d = {din, pr_q[N-1:1]};
        end
        if (load) begin
            dout_d = pr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pr_q   <= '0;
            dout_q <= '0;
        end else begin
            pr_q   <= pr_d;
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/spm_ctrl.sv
// Sequencer for the serial-parallel multiplier: latches operands, streams the
// sign-extended multiplier LSB first and collects the serial product.
//
// state | meaning
// IDLE  | waiting for start; datapath held in clear
// CLEAR | one cycle of datapath clear, counter zeroed
// RUN   | 2*WIDTH+PLAT cycles of serial feed and product capture
// DONE  | one-cycle done pulse; p just loaded
module spm_ctrl
    import spm_pkg::*;
#(
    parameter int WIDTH = SPM_WIDTH,
    parameter int PLAT  = SPM_PLAT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p,
    output logic [WIDTH-1:0]   spm_x,
    output logic               spm_y,
    output logic               spm_clr,
    input  logic               spm_p
);

    localparam int NCYC = 2 * WIDTH + PLAT;
    localparam int CW   = $clog2(NCYC + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(NCYC - 1);
    localparam logic [CW-1:0] CNT_W    = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_2W   = CW'(2 * WIDTH);
    localparam logic [CW:0]   PLAT_X   = (CW + 1)'(PLAT);

    spm_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] xr_q, xr_d;
    logic [WIDTH-1:0] yr_q, yr_d;
    logic [WIDTH-1:0] yr_sh;
    logic             shift_en;
    logic             load;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        xr_d     = xr_q;
        yr_d     = yr_q;
        busy     = 1'b0;
        done     = 1'b0;
        spm_clr  = 1'b0;
        spm_y    = 1'b0;
        shift_en = 1'b0;
        load     = 1'b0;
        yr_sh    = yr_q >> cnt_q;

        case (state_q)
            IDLE: begin
                spm_clr = 1'b1;
                if (start) begin
                    xr_d    = a;
                    yr_d    = b;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                busy    = 1'b1;
                spm_clr = 1'b1;
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                busy = 1'b1;
                // low WIDTH counts send y itself, the next WIDTH its sign, then zeros
                if (cnt_q < CNT_W) begin
                    spm_y = yr_sh[0];
                end else if (cnt_q < CNT_2W) begin
                    spm_y = yr_q[WIDTH-1];
                end
                // the first PLAT counts only fill the datapath pipeline
                shift_en = ({1'b0, cnt_q} + (CW + 1)'(1)) > PLAT_X;
                if (cnt_q == CNT_LAST) begin
                    load    = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            xr_q    <= '0;
            yr_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            xr_q    <= xr_d;
            yr_q    <= yr_d;
        end
    end

    assign spm_x = xr_q;

    spm_deser #(
        .N(2 * WIDTH)
    ) u_deser (
        .clk      (clk),
        .rst_n    (rst),
        .shift_en (shift_en),
        .din      (spm_p),
        .load     (load),
        .dout     (p)
    );

endmodule

// File: tb/tb_spm_ctrl.sv
// Bench for spm_ctrl: five controller instances, each driven by a behavioural
// serial multiplier (lanes 0-3: WIDTH=32, PLAT=lane; lane 4: WIDTH=4, PLAT=1).
module tb_spm_ctrl;

    localparam int NL = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        rst_v     [NL];
    logic        start_v   [NL];
    logic [31:0] a_v       [NL];
    logic [31:0] b_v       [NL];
    logic        busy_v    [NL];
    logic        done_v    [NL];
    logic        spm_y_v   [NL];
    logic        spm_clr_v [NL];
    logic [63:0] p_v       [NL];
    logic [31:0] x_v       [NL];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < NL; g++) begin : g_lane
        localparam int LW = (g == 4) ? 4 : 32;
        localparam int LP = (g == 4) ? 1 : g;

        logic [LW-1:0]   l_x;
        logic [2*LW-1:0] l_p;
        logic [2*LW-1:0] yacc = '0;
        logic [2*LW-1:0] ycur, xs, prod, prod_sh;
        logic            l_busy, l_done, l_y, l_clr, l_sp, bit0;
        logic [3:0]      dly = 4'd0;
        logic [3:0]      dly_ext;
        int              k = 0;

        spm_ctrl #(
            .WIDTH(LW),
            .PLAT (LP)
        ) u_dut (
            .clk     (clk),
            .rst     (rst_v[g]),
            .start   (start_v[g]),
            .a       (a_v[g][LW-1:0]),
            .b       (b_v[g][LW-1:0]),
            .busy    (l_busy),
            .done    (l_done),
            .p       (l_p),
            .spm_x   (l_x),
            .spm_y   (l_y),
            .spm_clr (l_clr),
            .spm_p   (l_sp)
        );

        // product bit k depends only on y bits 0..k, so multiply by what has arrived
        always_comb begin
            ycur    = yacc | ((2 * LW)'(l_y) << k);
            xs      = {{LW{l_x[LW-1]}}, l_x};
            prod    = xs * ycur;
            prod_sh = prod >> k;
            bit0    = prod_sh[0];
            dly_ext = {dly[2:0], bit0};
            l_sp    = dly_ext[LP];
        end

        always_ff @(posedge clk) begin
            dly <= dly_ext;
            if (l_clr) begin
                yacc <= '0;
                k    <= 0;
            end else begin
                yacc <= ycur;
                if (k < 4 * LW) k <= k + 1;
            end
        end

        assign busy_v[g]    = l_busy;
        assign done_v[g]    = l_done;
        assign spm_y_v[g]   = l_y;
        assign spm_clr_v[g] = l_clr;
        assign p_v[g]       = 64'(l_p);
        assign x_v[g]       = 32'(l_x);
    end

    task automatic reset_lane(input int l);
        @(negedge clk);
        rst_v[l]   = 1'b0;
        start_v[l] = 1'b0;
        repeat (2) @(negedge clk);
        rst_v[l] = 1'b1;
    endtask

    task automatic issue(input int l, input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        a_v[l]     = av;
        b_v[l]     = bv;
        start_v[l] = 1'b1;
        @(negedge clk);
        start_v[l] = 1'b0;
    endtask

    // n counts edges after the accepting edge until done is seen (capped at 300)
    task automatic wait_done(input int l, output int n, output int bcnt, output logic [15:0] yseq);
        n    = 0;
        bcnt = 0;
        yseq = '0;
        while (done_v[l] !== 1'b1 && n < 300) begin
            if (busy_v[l] === 1'b1) bcnt++;
            if (n >= 1 && n <= 16) yseq = yseq | (16'(spm_y_v[l]) << (n - 1));
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_op(input int l, input logic [31:0] av, input logic [31:0] bv,
                          output int n, output int bcnt, output logic [15:0] yseq);
        issue(l, av, bv);
        wait_done(l, n, bcnt, yseq);
    endtask

    task automatic main_seq();
        int          n, bc;
        logic [15:0] ys;
        @(negedge clk);
        check("rst_busy", 64'(busy_v[1]), 64'd0);
        check("rst_done", 64'(done_v[1]), 64'd0);
        check("rst_p", p_v[1], 64'd0);
        check("rst_x", 64'(x_v[1]), 64'd0);
        check("rst_y", 64'(spm_y_v[1]), 64'd0);
        check("rst_clr", 64'(spm_clr_v[1]), 64'd1);
        rst_v[1] = 1'b1;
        @(negedge clk);
        check("idle_clr", 64'(spm_clr_v[1]), 64'd1);

        run_op(1, 32'd3, 32'd5, n, bc, ys);
        check("lat_3x5", 64'(n), 64'd66);
        check("busy_3x5", 64'(bc), 64'd66);
        check("p_3x5", p_v[1], 64'd15);
        @(negedge clk);
        check("done_pulse", 64'(done_v[1]), 64'd0);
        check("idle_busy", 64'(busy_v[1]), 64'd0);
        check("p_hold", p_v[1], 64'd15);

        run_op(1, 32'hFFFF_FFFF, 32'd2, n, bc, ys);
        check("p_m1x2", p_v[1], 64'hFFFF_FFFF_FFFF_FFFE);
        run_op(1, 32'h8000_0000, 32'h8000_0000, n, bc, ys);
        check("p_minxmin", p_v[1], 64'h4000_0000_0000_0000);

        issue(1, 32'd9, 32'd11);
        repeat (20) @(negedge clk);
        a_v[1]     = 32'd7;
        b_v[1]     = 32'd7;
        start_v[1] = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b0;
        check("x_hold", 64'(x_v[1]), 64'd9);
        wait_done(1, n, bc, ys);
        check("p_ignore", p_v[1], 64'd99);

        run_op(1, 32'hFFFF_FFFD, 32'd5, n, bc, ys);
        check("lat_b2b", 64'(n), 64'd66);
        check("p_b2b", p_v[1], 64'hFFFF_FFFF_FFFF_FFF1);

        @(negedge clk);
        a_v[1]     = 32'd2;
        b_v[1]     = 32'd3;
        start_v[1] = 1'b1;
        @(negedge clk);
        wait_done(1, n, bc, ys);
        check("held_lat", 64'(n), 64'd66);
        check("held_p", p_v[1], 64'd6);
        @(negedge clk);
        check("held_idle", 64'(busy_v[1]), 64'd0);
        @(negedge clk);
        check("held_rearm", 64'(busy_v[1]), 64'd1);
        start_v[1] = 1'b0;
        wait_done(1, n, bc, ys);
        check("held_p2", p_v[1], 64'd6);

        issue(1, 32'd100, 32'd3);
        repeat (21) @(negedge clk);
        rst_v[1] = 1'b0;
        #1;
        check("abort_busy", 64'(busy_v[1]), 64'd0);
        check("abort_done", 64'(done_v[1]), 64'd0);
        check("abort_p", p_v[1], 64'd0);
        check("abort_clr", 64'(spm_clr_v[1]), 64'd1);
        check("abort_x", 64'(x_v[1]), 64'd0);
        check("abort_y", 64'(spm_y_v[1]), 64'd0);
        @(negedge clk);
        rst_v[1] = 1'b1;
        @(negedge clk);
        check("post_busy", 64'(busy_v[1]), 64'd0);
        check("post_clr", 64'(spm_clr_v[1]), 64'd1);
        run_op(1, 32'd6, 32'hFFFF_FFFC, n, bc, ys);
        check("lat_6xm4", 64'(n), 64'd66);
        check("p_6xm4", p_v[1], 64'hFFFF_FFFF_FFFF_FFE8);
    endtask

    task automatic rand_lane(input int l, input int plat, input int nops);
        int          n, bc;
        logic [15:0] ys;
        logic [31:0] av, bv;
        logic [63:0] e;
        reset_lane(l);
        for (int i = 0; i < nops; i++) begin
            av = $urandom;
            bv = $urandom;
            if (i == 0) begin av = 32'h8000_0000; bv = 32'h8000_0000; end
            if (i == 1) begin av = 32'h7FFF_FFFF; bv = 32'h8000_0000; end
            if (i == 2) begin av = 32'hFFFF_FFFF; bv = 32'hFFFF_FFFF; end
            e = 64'(longint'($signed(av)) * longint'($signed(bv)));
            run_op(l, av, bv, n, bc, ys);
            check($sformatf("rnd_p_plat%0d", plat), p_v[l], e);
            check($sformatf("rnd_lat_plat%0d", plat), 64'(n), 64'(2 * 32 + plat + 1));
        end
    endtask

    task automatic w4_seq();
        int          n, bc;
        logic [15:0] ys;
        reset_lane(4);
        run_op(4, 32'h8, 32'h8, n, bc, ys);
        check("w4_p_m8xm8", p_v[4], 64'h40);
        check("w4_lat", 64'(n), 64'd10);
        check("w4_yseq", 64'(ys), 64'h00F8);
        run_op(4, 32'h3, 32'hE, n, bc, ys);
        check("w4_p_3xm2", p_v[4], 64'hFA);
        run_op(4, 32'h8, 32'h7, n, bc, ys);
        check("w4_p_m8x7", p_v[4], 64'hC8);
    endtask

    initial begin
        for (int l = 0; l < NL; l++) begin
            rst_v[l]   = 1'b0;
            start_v[l] = 1'b0;
            a_v[l]     = '0;
            b_v[l]     = '0;
        end
        fork
            main_seq();
            rand_lane(0, 0, 300);
            rand_lane(2, 2, 300);
            rand_lane(3, 3, 300);
            w4_seq();
        join
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
